// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO peripheral on the data-memory bus.
//   LEDs, multi-digit 7-segment display, debounced switches with W1C edge
//   capture, per-switch interrupt mask and a level interrupt.
//   Optional feature macro: MMIO_GPIO_DEBOUNCE_EN (prescaled two-sample
//   debounce). Without it the debounced register follows the synchroniser.
//
// Bus handshake: a bus cycle is valid when clken is high on a rising edge;
// address/byteena/data/wren are captured then. Read data q is combinational
// from the captured address (one-cycle latency). A captured write commits on
// the following edge and the captured wren is dropped on any edge where
// clken is low, so each clken pulse produces at most one write.
//
// Register map (word addresses, full decode, unmapped reads return 0):
//   0x0 CONFIG   [3:0] b0 LED en, b1 hex en, b2 segment mode, b3 IRQ en
//   0x1 LED      RW
//   0x2 HEX0     RW digits 0..3 (one byte each)
//   0x3 HEX1     RW digits 4..7
//   0x4 SWITCH   RO debounced state
//   0x5 EDGE     W1C change flags, a new edge wins over a same-cycle clear
//   0x6 IRQ_MASK RW per-switch
module mmio_gpio #(
  parameter int ADDR_WIDTH      = 14,
  parameter int LED_COUNT       = 10,
  parameter int HEX_DIGITS      = 6,
  parameter int SWITCH_COUNT    = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [3:0]              byteena,
  input  logic                    clken,
  input  logic [31:0]             data,
  input  logic                    wren,
  output logic [31:0]             q,
  output logic [LED_COUNT-1:0]    led,
  output logic [8*HEX_DIGITS-1:0] hex,
  input  logic [SWITCH_COUNT-1:0] switch,
  output logic                    irq
);

  localparam logic [ADDR_WIDTH-1:0] A_CONFIG = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_LED    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_HEX0   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_HEX1   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_SWITCH = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_MASK   = ADDR_WIDTH'(6);

  // Captured bus cycle
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           data_q;
  logic                  wren_q;

  // Architectural registers
  logic [3:0]              cfg_q,  cfg_d;
  logic [LED_COUNT-1:0]    led_q,  led_d;
  logic [8*HEX_DIGITS-1:0] hex_q,  hex_d;
  logic [SWITCH_COUNT-1:0] mask_q, mask_d;
  logic [SWITCH_COUNT-1:0] edge_q, edge_d;

  // Switch path
  logic [SWITCH_COUNT-1:0] sw_meta_q;
  logic [SWITCH_COUNT-1:0] sw_sync_q;
  logic [SWITCH_COUNT-1:0] sw_db_q, sw_db_d;
  logic [SWITCH_COUNT-1:0] edge_set;
  logic [SWITCH_COUNT-1:0] edge_clr;

  // Write decode
  logic [31:0] lane_m;
  logic        wr_cfg, wr_led, wr_hex0, wr_hex1, wr_edge, wr_mask;
  logic [31:0] rdata;

  assign lane_m  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign wr_cfg  = wren_q && (addr_q == A_CONFIG);
  assign wr_led  = wren_q && (addr_q == A_LED);
  assign wr_hex0 = wren_q && (addr_q == A_HEX0);
  assign wr_hex1 = wren_q && (addr_q == A_HEX1);
  assign wr_edge = wren_q && (addr_q == A_EDGE);
  assign wr_mask = wren_q && (addr_q == A_MASK);

  // Bits of the bus data/lane mask that narrow registers never look at
  logic unused_bus;
  assign unused_bus = ^{data_q, lane_m};

  // Hex digit segment pattern for a nibble, active-low, decimal point off
  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Capture the bus cycle; the write strobe lives for one edge only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      be_q   <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else if (clken) begin
      addr_q <= address;
      be_q   <= byteena;
      data_q <= data;
      wren_q <= wren;
    end else begin
      wren_q <= 1'b0;
    end
  end

  // Next state of the software-visible registers
  always_comb begin
    cfg_d = cfg_q;
    if (wr_cfg && be_q[0]) cfg_d = data_q[3:0];

    led_d = led_q;
    if (wr_led)
      led_d = (led_q & ~lane_m[LED_COUNT-1:0]) | (data_q[LED_COUNT-1:0] & lane_m[LED_COUNT-1:0]);

    mask_d = mask_q;
    if (wr_mask)
      mask_d = (mask_q & ~lane_m[SWITCH_COUNT-1:0]) | (data_q[SWITCH_COUNT-1:0] & lane_m[SWITCH_COUNT-1:0]);

    hex_d = hex_q;
    for (int d = 0; d < HEX_DIGITS; d++) begin
      if (((d < 4) ? wr_hex0 : wr_hex1) && be_q[d % 4])
        hex_d[8*d +: 8] = data_q[8*(d % 4) +: 8];
    end

    // Set has priority: a bit that changes this edge stays flagged
    edge_clr = '0;
    if (wr_edge) edge_clr = data_q[SWITCH_COUNT-1:0] & lane_m[SWITCH_COUNT-1:0];
    edge_set = sw_db_d ^ sw_db_q;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
  end

`ifdef MMIO_GPIO_DEBOUNCE_EN
  localparam int PW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [SWITCH_COUNT-1:0] sw_samp_q, sw_samp_d;
  logic [SWITCH_COUNT-1:0] sw_agree;
  logic                    tick;

  // Prescaler and two-sample agreement: a bit only moves when two
  // consecutive tick samples agree, so sub-tick glitches never reach it
  always_comb begin
    tick      = (presc_q == PW'(DEBOUNCE_CYCLES - 1));
    presc_d   = tick ? '0 : presc_q + PW'(1);
    sw_samp_d = tick ? sw_sync_q : sw_samp_q;
    sw_agree  = ~(sw_sync_q ^ sw_samp_q);
    sw_db_d   = sw_db_q;
    if (tick) sw_db_d = (sw_sync_q & sw_agree) | (sw_db_q & ~sw_agree);
  end

  // Prescaler and previous-sample registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      sw_samp_q <= '0;
    end else begin
      presc_q   <= presc_d;
      sw_samp_q <= sw_samp_d;
    end
  end
`else
  // Debounce bypassed: follow the synchroniser every cycle
  always_comb begin
    sw_db_d = sw_sync_q;
  end
`endif

  // Register file and switch path state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q     <= '0;
      led_q     <= '0;
      hex_q     <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_db_q   <= '0;
    end else begin
      cfg_q     <= cfg_d;
      led_q     <= led_d;
      hex_q     <= hex_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      sw_db_q   <= sw_db_d;
    end
  end

  // Read mux from the captured address; unused bits and holes read 0
  always_comb begin
    rdata = '0;
    case (addr_q)
      A_CONFIG: rdata[3:0] = cfg_q;
      A_LED:    rdata[LED_COUNT-1:0] = led_q;
      A_HEX0: begin
        for (int d = 0; d < HEX_DIGITS && d < 4; d++)
          rdata[8*d +: 8] = hex_q[8*d +: 8];
      end
      A_HEX1: begin
        for (int d = 4; d < HEX_DIGITS; d++)
          rdata[8*(d % 4) +: 8] = hex_q[8*d +: 8];
      end
      A_SWITCH: rdata[SWITCH_COUNT-1:0] = sw_db_q;
      A_EDGE:   rdata[SWITCH_COUNT-1:0] = edge_q;
      A_MASK:   rdata[SWITCH_COUNT-1:0] = mask_q;
      default:  rdata = '0;
    endcase
  end

  assign q   = rdata;
  assign led = cfg_q[0] ? led_q : '0;
  assign irq = cfg_q[3] & |(edge_q & mask_q);

  // Segment drive: blank, raw segment bytes, or decoded nibble per digit
  always_comb begin
    hex = '1;
    for (int d = 0; d < HEX_DIGITS; d++) begin
      if (!cfg_q[1])
        hex[8*d +: 8] = 8'hFF;
      else if (cfg_q[2])
        hex[8*d +: 8] = ~hex_q[8*d +: 8];
      else
        hex[8*d +: 8] = glyph(hex_q[4*d +: 4]);
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed bench for mmio_gpio with a read scoreboard.
module tb_mmio_gpio;

  localparam int AW = 14;
  localparam int LN = 10;
  localparam int HD = 6;
  localparam int SN = 10;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteena = '0;
  logic          clken = 1'b0;
  logic [31:0]   data = '0;
  logic          wren = 1'b0;
  logic [31:0]   q;
  logic [LN-1:0] led;
  logic [8*HD-1:0] hex;
  logic [SN-1:0] switch = '0;
  logic          irq;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] v;

  mmio_gpio #(
    .ADDR_WIDTH(AW), .LED_COUNT(LN), .HEX_DIGITS(HD),
    .SWITCH_COUNT(SN), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .byteena(byteena),
    .clken(clken), .data(data), .wren(wren), .q(q), .led(led), .hex(hex),
    .switch(switch), .irq(irq)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address = a; data = d; byteena = be; wren = 1'b1; clken = 1'b1;
    @(negedge clock);
    clken = 1'b0; wren = 1'b0;
    @(negedge clock);
  endtask

  task automatic bus_read_raw(input logic [AW-1:0] a, output logic [31:0] r);
    @(negedge clock);
    address = a; wren = 1'b0; clken = 1'b1;
    @(negedge clock);
    clken = 1'b0;
    r = q;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] expv);
    logic [31:0] r;
    exp_q.push_back(expv);
    bus_read_raw(a, r);
    check(tag, r, exp_q.pop_front());
  endtask

  task automatic wait_switch(input string tag, input logic [31:0] target);
    logic [31:0] r;
    r = ~target;
    for (int k = 0; k < 40 && r != target; k++) bus_read_raw(14'h4, r);
    check(tag, r, target);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_q", q, 0);
    read_check("reset_config", 14'h0, 32'h0);
    read_check("reset_switch", 14'h4, 32'h0);
    read_check("reset_edge", 14'h5, 32'h0);
    check("reset_led", led, 0);
    check("reset_hex", hex, 48'hFFFF_FFFF_FFFF);
    check("reset_irq", irq, 0);

    // Glyph mode
    bus_write(14'h0, 32'h3, 4'hF);
    bus_write(14'h2, 32'h0000_0021, 4'hF);
    read_check("hex0_rb", 14'h2, 32'h0000_0021);
    check("hex_glyph_21", hex, 48'hC0C0_C0C0_A4F9);
    bus_write(14'h3, 32'h7777_5A3C, 4'hF);
    read_check("hex1_rb_absent", 14'h3, 32'h0000_5A3C);

    // Segment mode
    bus_write(14'h0, 32'h7, 4'h1);
    check("hex_segment", hex, 48'hA5C3_FFFF_FFDE);
    bus_write(14'h2, 32'h0000_BEAD, 4'hF);
    bus_write(14'h0, 32'h3, 4'h1);
    check("hex_glyph_letters", hex, 48'hC0C0_8386_88A1);
    bus_write(14'h0, 32'hF, 4'h2);
    read_check("config_lane0_only", 14'h0, 32'h3);

    // LED byte lanes, full decode, unmapped
    bus_write(14'h1, 32'h3FF, 4'b0001);
    read_check("led_lane0", 14'h1, 32'h0FF);
    check("led_out_lane0", led, 10'h0FF);
    bus_write(14'h1, 32'h3FF, 4'b0010);
    read_check("led_lane1", 14'h1, 32'h3FF);
    check("led_out_full", led, 10'h3FF);
    bus_write(14'h2001, 32'h0, 4'hF);
    read_check("led_alias_ignored", 14'h1, 32'h3FF);
    read_check("unmapped_7", 14'h7, 32'h0);
    read_check("unmapped_alias", 14'h2002, 32'h0);
    bus_write(14'h0, 32'h2, 4'h1);
    check("led_disabled", led, 10'h000);
    check("hex_still_on", hex, 48'hC0C0_8386_88A1);

    // One write per clken pulse even with wren held
    @(negedge clock);
    address = 14'h1; data = 32'h155; byteena = 4'b0011; wren = 1'b1; clken = 1'b1;
    @(negedge clock);
    clken = 1'b0; data = 32'h2AA;
    repeat (4) @(negedge clock);
    wren = 1'b0;
    read_check("single_write", 14'h1, 32'h155);

    // Debounced switch, edge capture, interrupt
    bus_write(14'h0, 32'h8, 4'h1);
    bus_write(14'h6, 32'h4, 4'hF);
    read_check("mask_rb", 14'h6, 32'h4);
    check("irq_idle", irq, 0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clock); switch[2] = 1'b1;
      @(negedge clock); switch[2] = 1'b0;
      repeat (3) @(negedge clock);
    end
    switch[2] = 1'b1;
    wait_switch("switch_settle_rise", 32'h004);
    read_check("edge_rise", 14'h5, 32'h004);
    check("irq_rise", irq, 1);
    bus_write(14'h5, 32'h4, 4'h1);
    read_check("edge_w1c", 14'h5, 32'h0);
    check("irq_cleared", irq, 0);

`ifdef MMIO_GPIO_DEBOUNCE_EN
    switch[2] = 1'b0;
    wait_switch("switch_settle_fall", 32'h000);
    read_check("edge_fall", 14'h5, 32'h004);
`else
    // Falling edge reaches the register on the third edge; the W1C is
    // timed to commit on that same edge, and the set must win
    @(negedge clock);
    switch[2] = 1'b0;
    bus_write(14'h5, 32'h4, 4'h1);
    read_check("edge_set_wins", 14'h5, 32'h004);
    read_check("switch_fall", 14'h4, 32'h000);
`endif
    check("irq_fall", irq, 1);
    bus_write(14'h5, 32'h4, 4'h1);
    read_check("edge_w1c_again", 14'h5, 32'h0);
    check("irq_cleared_again", irq, 0);

    // Masked switch raises EDGE but not irq
    switch[5] = 1'b1;
    wait_switch("switch5_settle", 32'h020);
    read_check("edge_sw5", 14'h5, 32'h020);
    check("irq_masked", irq, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
